arithmetic_logic_unit: RTL and testbench

ARITHMETIC_LOGIC_UNIT -- requirements
Module: arithmetic_logic_unit

---
 rtl/arithmetic_logic_unit.sv | 77 +++++++
 tb/tb_arithmetic_logic_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/arithmetic_logic_unit.sv
// Single-cycle registered ALU: computes one of ten operations on two
// WIDTH-bit operands and registers the result, a zero flag and a valid
// strobe. Accepts a new request every cycle; no backpressure.
module arithmetic_logic_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [3:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero
);

    // Shift amounts use the low log2(WIDTH) bits of operandB.
    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SLL = 4'b0001,
        OP_SLA = 4'b0010,
        OP_SLT = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SRL = 4'b0101,
        OP_OR  = 4'b0110,
        OP_AND = 4'b0111,
        OP_SUB = 4'b1000,
        OP_SRA = 4'b1101
    } alu_op_e;

    logic [SHW-1:0]   shamt;
    logic             less_than;
    logic [WIDTH-1:0] f;

    assign shamt     = operandB[SHW-1:0];
    assign less_than = $signed(operandA) < $signed(operandB);

    // Combinational operation select; unlisted codes pass operandA through.
    always_comb begin
        f = operandA;
        case (alu_op_e'(operation))
            OP_ADD:  f = operandA + operandB;
            OP_SUB:  f = operandA - operandB;
            OP_SLL:  f = operandA << shamt;
            OP_SLA:  f = operandA << shamt;
            OP_SLT:  begin
                f    = '0;
                f[0] = less_than;
            end
            OP_XOR:  f = operandA ^ operandB;
            OP_SRL:  f = operandA >> shamt;
            OP_SRA:  f = WIDTH'($signed(operandA) >>> shamt);
            OP_OR:   f = operandA | operandB;
            OP_AND:  f = operandA & operandB;
            default: f = operandA;
        endcase
    end

    // Output registers: reset wins over a valid request; idle cycles hold result/zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            result    <= f;
            zero      <= (f == '0);
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Self-checking bench for arithmetic_logic_unit: directed vectors plus a
// randomized stream compared against an arithmetic reference model.
module tb_arithmetic_logic_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [3:0]  operation;
    logic [31:0] result;
    logic        out_valid;
    logic        zero;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard view of the registered outputs.
    logic [31:0] m_result;
    logic        m_zero;
    logic        m_valid;

    always #5 clk = ~clk;

    arithmetic_logic_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .operandA  (operandA),
        .operandB  (operandB),
        .operation (operation),
        .result    (result),
        .out_valid (out_valid),
        .zero      (zero)
    );

    // Reference model: operations expressed as plain integer arithmetic.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        longint unsigned ua  = {32'd0, a};
        longint unsigned ub  = {32'd0, b};
        longint unsigned pw  = 64'd1 << (b % 32);
        longint          sa  = longint'($signed(a));
        longint          sb  = longint'($signed(b));
        longint          q;
        longint unsigned tmp;
        case (op)
            4'd0: begin tmp = (ua + ub) % 64'h1_0000_0000; return tmp[31:0]; end
            4'd8: begin tmp = (ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000; return tmp[31:0]; end
            4'd1, 4'd2: begin tmp = (ua * pw) % 64'h1_0000_0000; return tmp[31:0]; end
            4'd3: return (sa < sb) ? 32'd1 : 32'd0;
            4'd4: return a ^ b;
            4'd5: begin tmp = ua / pw; return tmp[31:0]; end
            4'd13: begin
                // floor division by 2^s
                if (sa >= 0) q = sa / longint'(pw);
                else         q = -((-sa + longint'(pw) - 1) / longint'(pw));
                return q[31:0];
            end
            4'd6: return a | b;
            4'd7: return a & b;
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // One clock: apply inputs, advance, update model, compare all outputs.
    task automatic step(input bit rst, input bit valid, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op);
        rst_n     = ~rst;
        in_valid  = valid;
        operandA  = a;
        operandB  = b;
        operation = op;
        @(posedge clk);
        #1;
        if (rst) begin
            m_result = 32'd0;
            m_zero   = 1'b0;
            m_valid  = 1'b0;
        end else if (valid) begin
            m_result = model(a, b, op);
            m_zero   = (m_result == 32'd0);
            m_valid  = 1'b1;
        end else begin
            m_valid  = 1'b0;
        end
        check("result", result, m_result);
        check("zero", {31'd0, zero}, {31'd0, m_zero});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] exp);
        step(1'b0, 1'b1, a, b, op);
        check(tag, result, exp);
    endtask

    logic [31:0] ra, rb;

    initial begin
        // Reset together with a valid request: request dropped.
        step(1'b1, 1'b1, 32'd5, 32'd3, 4'b0000);
        check("rst_result", result, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        step(1'b1, 1'b0, 32'd0, 32'd0, 4'b0000);

        // Back-to-back directed requests.
        directed("add", 32'd5, 32'd3, 4'b0000, 32'd8);
        directed("sub", 32'd5, 32'd3, 4'b1000, 32'd2);
        directed("sub_wrap", 32'd0, 32'd1, 4'b1000, 32'hFFFF_FFFF);
        check("sub_wrap_zero", {31'd0, zero}, 32'd0);
        directed("add_ovf", 32'hFFFF_FFFF, 32'd2, 4'b0000, 32'd1);
        directed("and", 32'h0000_F0F0, 32'h0000_FF00, 4'b0111, 32'h0000_F000);
        directed("or", 32'h0000_F0F0, 32'h0000_0F0F, 4'b0110, 32'h0000_FFFF);
        directed("xor", 32'h0000_FFFF, 32'h0000_F0F0, 4'b0100, 32'h0000_0F0F);
        directed("sll", 32'd1, 32'd2, 4'b0001, 32'd4);
        directed("sla", 32'd1, 32'd2, 4'b0010, 32'd4);
        directed("srl", 32'd8, 32'd1, 4'b0101, 32'd4);
        directed("sra", 32'h8000_0000, 32'd1, 4'b1101, 32'hC000_0000);
        directed("srl_msb", 32'h8000_0000, 32'd1, 4'b0101, 32'h4000_0000);
        directed("sll_ovr", 32'd1, 32'h21, 4'b0001, 32'd2);
        directed("sh_zero", 32'h1234_5678, 32'hFFFF_FFE0, 4'b0101, 32'h1234_5678);
        directed("slt_neg", 32'hFFFF_FFFF, 32'd1, 4'b0011, 32'd1);
        directed("slt_pos", 32'd1, 32'hFFFF_FFFF, 4'b0011, 32'd0);
        directed("slt_eq", 32'h8000_0000, 32'h8000_0000, 4'b0011, 32'd0);
        directed("pass_f", 32'd5, 32'd9, 4'b1111, 32'd5);
        directed("pass_9", 32'hDEAD_BEEF, 32'd1, 4'b1001, 32'hDEAD_BEEF);
        directed("sub_eq", 32'd5, 32'd5, 4'b1000, 32'd0);
        check("sub_eq_zero", {31'd0, zero}, 32'd1);

        // Idle cycle: out_valid drops, result and zero hold.
        directed("pre_hold", 32'd7, 32'd0, 4'b1110, 32'd7);
        step(1'b0, 1'b0, 32'd99, 32'd1, 4'b0000);
        check("hold_result", result, 32'd7);
        check("hold_valid", {31'd0, out_valid}, 32'd0);

        // Mid-stream reset, then normal 1-cycle latency on the next request.
        step(1'b1, 1'b1, 32'd1, 32'd1, 4'b0000);
        directed("post_rst", 32'd10, 32'd20, 4'b0000, 32'd30);

        // Randomized stream with occasional idles and resets.
        for (int i = 0; i < 600; i++) begin
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: rb = $urandom_range(0, 40);
                2: ra = ra | 32'h8000_0000;
                default: ;
            endcase
            step($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
                 ra, rb, 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
